// File: rtl/one_to_two_st_demux_pkg.sv
// Shared definitions for the one-to-two AXI-Stream packet demultiplexer.
// Holds the default data width, packet counter width and the route FSM
// state encoding, plus a small helper mapping a select bit to a lock state.
package one_to_two_st_demux_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_A = 2'd1,
        ST_LOCK_B = 2'd2
    } route_state_t;

    // Lock state entered when a multi-beat packet starts toward to_b's output.
    function automatic route_state_t lock_of(input logic to_b);
        return to_b ? ST_LOCK_B : ST_LOCK_A;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-Stream output register (valid, data, last).
// Ports: clk/reset; load + load_data/load_last from the router; tready from
// the sink; tvalid/tdata/tlast to the sink; free = can take a beat this cycle;
// done_pkt = a last beat leaves this cycle.
module axis_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              tready,
    output logic              tvalid,
    output logic [DATA_W-1:0] tdata,
    output logic              tlast,
    output logic              free,
    output logic              done_pkt
);

    // Empty, or the current beat leaves this cycle: a load here keeps full rate.
    assign free     = !tvalid || tready;
    assign done_pkt = tvalid && tready && tlast;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tlast  <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= load_data;
            tlast  <= load_last;
        end else if (tready) begin
            // Data/last are held until overwritten by the next load.
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/one_to_two_st_demux.sv
// One-to-two AXI-Stream packet demultiplexer with per-output packet counters.
// Ports: clk/reset; sel (sampled at packet start); s_axis_* input stream;
// m_axis_*_A / m_axis_*_B output streams; pkt_count_A/B completed packets.
module one_to_two_st_demux
    import one_to_two_st_demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata_A,
    output logic              m_axis_tvalid_A,
    output logic              m_axis_tlast_A,
    input  logic              m_axis_tready_A,
    output logic [DATA_W-1:0] m_axis_tdata_B,
    output logic              m_axis_tvalid_B,
    output logic              m_axis_tlast_B,
    input  logic              m_axis_tready_B,
    output logic [CNT_W-1:0]  pkt_count_A,
    output logic [CNT_W-1:0]  pkt_count_B
);

    route_state_t state, state_nxt;
    logic         route_b;
    logic         accept;
    logic         free_a, free_b;
    logic         done_a, done_b;
    logic [CNT_W-1:0] cnt_a, cnt_b;

    // In IDLE the live sel decides, so single-beat packets route without a lock.
    assign route_b = (state == ST_LOCK_B) || ((state == ST_IDLE) && sel);

    // Ready follows only the selected output register, never s_axis_tvalid.
    assign s_axis_tready = !reset && (route_b ? free_b : free_a);
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept && !s_axis_tlast) state_nxt = lock_of(sel);
            ST_LOCK_A,
            ST_LOCK_B: if (accept && s_axis_tlast)  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    axis_out_reg #(.DATA_W(DATA_W)) u_out_a (
        .clk       (clk),
        .reset     (reset),
        .load      (accept && !route_b),
        .load_data (s_axis_tdata),
        .load_last (s_axis_tlast),
        .tready    (m_axis_tready_A),
        .tvalid    (m_axis_tvalid_A),
        .tdata     (m_axis_tdata_A),
        .tlast     (m_axis_tlast_A),
        .free      (free_a),
        .done_pkt  (done_a)
    );

    axis_out_reg #(.DATA_W(DATA_W)) u_out_b (
        .clk       (clk),
        .reset     (reset),
        .load      (accept && route_b),
        .load_data (s_axis_tdata),
        .load_last (s_axis_tlast),
        .tready    (m_axis_tready_B),
        .tvalid    (m_axis_tvalid_B),
        .tdata     (m_axis_tdata_B),
        .tlast     (m_axis_tlast_B),
        .free      (free_b),
        .done_pkt  (done_b)
    );

    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (done_a) cnt_a <= cnt_a + 1'b1;
            if (done_b) cnt_b <= cnt_b + 1'b1;
        end
    end

    assign pkt_count_A = cnt_a;
    assign pkt_count_B = cnt_b;

endmodule

// File: tb/tb_one_to_two_st_demux.sv
module tb_one_to_two_st_demux;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         sel;
    logic [W-1:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [W-1:0] m_axis_tdata_A, m_axis_tdata_B;
    logic         m_axis_tvalid_A, m_axis_tvalid_B;
    logic         m_axis_tlast_A, m_axis_tlast_B;
    logic         m_axis_tready_A, m_axis_tready_B;
    logic [31:0]  pkt_count_A, pkt_count_B;

    one_to_two_st_demux #(.DATA_W(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .sel             (sel),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .m_axis_tdata_A  (m_axis_tdata_A),
        .m_axis_tvalid_A (m_axis_tvalid_A),
        .m_axis_tlast_A  (m_axis_tlast_A),
        .m_axis_tready_A (m_axis_tready_A),
        .m_axis_tdata_B  (m_axis_tdata_B),
        .m_axis_tvalid_B (m_axis_tvalid_B),
        .m_axis_tlast_B  (m_axis_tlast_B),
        .m_axis_tready_B (m_axis_tready_B),
        .pkt_count_A     (pkt_count_A),
        .pkt_count_B     (pkt_count_B)
    );

    always #5 clk = ~clk;

    // Reference model: expected beats per output, packet-level route lock,
    // expected packet counts.
    beat_t       qa[$], qb[$];
    bit          in_pkt, lock_b;
    logic [31:0] cnt_m[2];
    bit          held_v[2];
    beat_t       held[2];
    bit          rdy_rand;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor side: one output port observed at a negedge.
    task automatic mon_one(input int p, input logic v, input logic r,
                           input logic [W-1:0] d, input logic l);
        beat_t e;
        if (held_v[p]) check(p == 0 ? "hold_A" : "hold_B", {v, d, l}, {1'b1, held[p]});
        held_v[p] = 1'b0;
        if (v && r) begin
            if ((p == 0 ? qa.size() : qb.size()) == 0) begin
                check(p == 0 ? "unexpected_A" : "unexpected_B", {d, l}, 0);
            end else begin
                e = (p == 0) ? qa.pop_front() : qb.pop_front();
                check(p == 0 ? "beat_A" : "beat_B", {d, l}, e);
                if (e.l) cnt_m[p] = cnt_m[p] + 1;
            end
        end else if (v) begin
            held_v[p] = 1'b1;
            held[p]   = {d, l};
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                mon_one(0, m_axis_tvalid_A, m_axis_tready_A, m_axis_tdata_A, m_axis_tlast_A);
                mon_one(1, m_axis_tvalid_B, m_axis_tready_B, m_axis_tdata_B, m_axis_tlast_B);
            end
        end
    end

    // Sink readiness: random when enabled, otherwise left to the main sequence.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) begin
                m_axis_tready_A = ($urandom_range(0, 3) != 0);
                m_axis_tready_B = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Offer one beat until accepted; returns 1 cycle-phase after the accept edge (+1).
    task automatic send_beat(input logic [W-1:0] d, input logic l, input logic s);
        bit rb;
        bit exp_rdy;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        sel           = s;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            rb      = in_pkt ? lock_b : sel;
            exp_rdy = rb ? (!m_axis_tvalid_B || m_axis_tready_B)
                         : (!m_axis_tvalid_A || m_axis_tready_A);
            check("s_tready", s_axis_tready, exp_rdy);
            if (s_axis_tready) break;
            if (t > 1000) begin
                check("accept_timeout", 0, 1);
                s_axis_tvalid = 1'b0;
                return;
            end
        end
        if (rb) qb.push_back({d, l});
        else    qa.push_back({d, l});
        if (l) in_pkt = 1'b0;
        else if (!in_pkt) begin
            in_pkt = 1'b1;
            lock_b = rb;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int len, input logic sel0, input logic sel_rest,
                            input logic [W-1:0] base, input bit gaps, input bit rnd_sel);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                sel           = $urandom_range(0, 1);
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            send_beat(base + W'(i), (i == len - 1),
                      (i == 0) ? sel0 : (rnd_sel ? 1'($urandom_range(0, 1)) : sel_rest));
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain_and_count(input string tag);
        s_axis_tvalid   = 1'b0;
        rdy_rand        = 1'b0;
        m_axis_tready_A = 1'b1;
        m_axis_tready_B = 1'b1;
        for (int t = 0; qa.size() != 0 || qb.size() != 0; t++) begin
            @(posedge clk);
            if (t > 500) begin
                check({tag, "_drain_timeout"}, qa.size() + qb.size(), 0);
                qa.delete();
                qb.delete();
            end
        end
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_cnt_A"}, pkt_count_A, cnt_m[0]);
        check({tag, "_cnt_B"}, pkt_count_B, cnt_m[1]);
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        in_pkt    = 1'b0;
        lock_b    = 1'b0;
        cnt_m[0]  = '0;
        cnt_m[1]  = '0;
        held_v[0] = 1'b0;
        held_v[1] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        sel             = 1'b0;
        s_axis_tdata    = '0;
        s_axis_tvalid   = 1'b0;
        s_axis_tlast    = 1'b0;
        m_axis_tready_A = 1'b1;
        m_axis_tready_B = 1'b1;
        rdy_rand        = 1'b0;
        model_reset();
        #1;
        check("rst_vld_A", m_axis_tvalid_A, 0);
        check("rst_vld_B", m_axis_tvalid_B, 0);
        check("rst_dat", {m_axis_tdata_A, m_axis_tdata_B, m_axis_tlast_A, m_axis_tlast_B}, 0);
        check("rst_cnt", {pkt_count_A, pkt_count_B}, 0);
        check("rst_s_tready", s_axis_tready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 4-beat packet to A: 1-cycle latency, back-to-back output.
        for (int i = 1; i <= 4; i++) begin
            send_beat(W'(i), (i == 4), 1'b0);
            check("lat_vld_A", m_axis_tvalid_A, 1);
            check("lat_dat_A", {m_axis_tdata_A, m_axis_tlast_A}, {W'(i), (i == 4)});
        end
        s_axis_tvalid = 1'b0;
        drain_and_count("p1");

        // sel toggles mid-packet: stays on A; next packet goes to B.
        send_pkt(5, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
        send_pkt(2, 1'b1, 1'b0, 32'h20, 1'b0, 1'b0);
        drain_and_count("p2");

        // Back-to-back single-beat packets.
        send_beat(32'hA, 1'b1, 1'b1);
        send_beat(32'hB, 1'b1, 1'b0);
        s_axis_tvalid = 1'b0;
        drain_and_count("p3");

        // Stall A for 3 cycles mid-packet.
        fork
            send_pkt(6, 1'b0, 1'b1, 32'h30, 1'b0, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1;
                m_axis_tready_A = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                m_axis_tready_A = 1'b1;
            end
        join
        drain_and_count("p4");

        // Randomized traffic with random sink readiness.
        rdy_rand = 1'b1;
        for (int p = 0; p < 60; p++)
            send_pkt($urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b0,
                     $urandom, 1'b1, 1'b1);
        drain_and_count("rand");

        // Reset during beat 3 of a 6-beat packet routed to B.
        send_beat(32'h100, 1'b0, 1'b1);
        send_beat(32'h101, 1'b0, 1'b1);
        s_axis_tdata = 32'h102;
        sel          = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        s_axis_tvalid = 1'b0;
        check("mrst_vld", {m_axis_tvalid_A, m_axis_tvalid_B}, 0);
        check("mrst_cnt", {pkt_count_A, pkt_count_B}, 0);
        check("mrst_s_tready", s_axis_tready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_pkt(3, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
        drain_and_count("post_rst");
        check("post_rst_A1", pkt_count_A, 1);

        // Counter wrap on A.
        @(negedge clk);
        force dut.cnt_a = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.cnt_a;
        cnt_m[0] = 32'hFFFF_FFFF;
        #1;
        check("preload_A", pkt_count_A, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        send_beat(32'h300, 1'b1, 1'b0);
        s_axis_tvalid = 1'b0;
        drain_and_count("wrap");
        check("wrap_A0", pkt_count_A, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/one_to_two_st_demux.md
ONE_TO_TWO_ST_DEMUX -- requirements
Module: one_to_two_st_demux

Interface
REQ-001 Parameter DATA_W, default 32, AXI-Stream tdata width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 sel  input  1  route select, sampled only at packet start; 0 = output A, 1 = output B.
REQ-005 s_axis_tdata  input  DATA_W  input stream data.
REQ-006 s_axis_tvalid  input  1  input beat valid.
REQ-007 s_axis_tready  output  1  input beat accept.
REQ-008 s_axis_tlast  input  1  last beat of input packet.
REQ-009 m_axis_tdata_A / m_axis_tvalid_A / m_axis_tlast_A  output  DATA_W/1/1  output stream A.
REQ-010 m_axis_tready_A  input  1  output A accept.
REQ-011 m_axis_tdata_B / m_axis_tvalid_B / m_axis_tlast_B  output  DATA_W/1/1  output stream B.
REQ-012 m_axis_tready_B  input  1  output B accept.
REQ-013 pkt_count_A / pkt_count_B  output  32 each  count of packets completed on A / B.

Function
REQ-014 Input beat accepted when s_axis_tvalid && s_axis_tready at a clk edge; output beat transferred when m_axis_tvalid_x && m_axis_tready_x.
REQ-015 Route FSM states: IDLE, LOCK_A, LOCK_B; IDLE at reset.
REQ-016 Effective route in IDLE = sel in the same cycle; in LOCK_A = A; in LOCK_B = B.
REQ-017 IDLE -> LOCK_A / LOCK_B on accepted beat with tlast=0, per sel in that cycle.
REQ-018 IDLE -> IDLE on accepted beat with tlast=1 (single-beat packet, routed per sel).
REQ-019 LOCK_x -> IDLE on accepted beat with tlast=1; otherwise held.
REQ-020 sel changes while in LOCK_x have no effect on routing of the current packet.
REQ-021 Each output has a one-entry register stage (valid, data, last).
REQ-022 s_axis_tready = (!m_axis_tvalid_x || m_axis_tready_x) for the effective route x; no dependence on s_axis_tvalid.
REQ-023 Accepted beat loads route-x register with tdata/tlast and sets valid; latency input-accept to m_axis_tvalid_x high = 1 cycle.
REQ-024 Register x with valid=1 and no load clears valid on its transfer; data/last held while valid && !tready.
REQ-025 Simultaneous transfer-out and load on the same register: new beat loaded, valid stays 1; full throughput of 1 beat/cycle sustained.
REQ-026 Non-routed output register unaffected by input activity; drains independently per its own tready.
REQ-027 pkt_count_x increments by 1 on each output-x transfer with tlast=1; wraps 0xFFFFFFFF -> 0.
REQ-028 Never duplicates, drops or reorders beats; tdata never modified.

Reset
REQ-029 reset asserted: FSM = IDLE; m_axis_tvalid_A/B = 0; m_axis_tdata_A/B = 0; m_axis_tlast_A/B = 0; pkt_count_A/B = 0, immediately (asynchronous).
REQ-030 s_axis_tready = 0 while reset asserted.
REQ-031 Reset mid-packet discards in-flight beats; first accepted beat after deassert treated as packet start.

Structure
REQ-032 Shared package holds DATA_W default (32) and the route FSM state encoding (IDLE, LOCK_A, LOCK_B).
REQ-033 Sub-module axis_out_reg (one-entry output register with load/transfer logic) instantiated twice, A and B.

Verification
REQ-034 sel=0, 4-beat packet 0x1..0x4 (tlast on 0x4), both treadys=1 -> A emits 0x1..0x4 on 4 consecutive cycles from 1 cycle after first accept, tlast on 0x4, pkt_count_A=1, B tvalid never high.
REQ-035 sel=0 at first beat, toggled to 1 on beat 2 of 5-beat packet -> all 5 beats on A; next packet with sel=1 -> B, pkt_count_B=1.
REQ-036 Single-beat packets 0xA (sel=1), 0xB (sel=0) back-to-back -> 0xA on B, 0xB on A, FSM stays IDLE, each count=1.
REQ-037 Route A, m_axis_tready_A=0 for 3 cycles mid-packet -> s_axis_tready=0 those cycles, A data held stable, no beat lost; B traffic stalled only if routed to A.
REQ-038 Reset asserted during beat 3 of 6-beat packet to B -> tvalid_A/B=0 and counts=0 immediately; post-reset packet with sel=0 routes to A.
REQ-039 pkt_count_A preloaded via 2^32 single-beat packets (or forced to 0xFFFFFFFF) then one more packet -> wraps to 0.
